// File: rtl/sym_delay_search_pkg.sv
// Shared types and defaults for the RX/TX symbol-alignment search.
package sym_delay_search_pkg;

  // Default sweep geometry: one window per candidate delay, full sweep is
  // (SDS_DEF_MAX_DELAY+1) * SDS_DEF_WIN_LEN symbols.
  localparam int SDS_DEF_WIN_LEN   = 256;
  localparam int SDS_DEF_MAX_DELAY = 127;

  // Search FSM encoding.
  typedef enum logic [0:0] {
    SDS_SEARCH = 1'b0,
    SDS_LOCKED = 1'b1
  } sds_state_e;

  // One symbol error: any difference between reference and sliced symbol.
  function automatic logic sym_mismatch(input logic [1:0] ref_sym, input logic [1:0] rx_sym);
    return (ref_sym != rx_sym);
  endfunction

endpackage

// File: rtl/sym_delay_search_if.sv
// Symbol-rate stream and status bundle of the delay search block.
interface sym_delay_search_if #(
  parameter int DELAY_W = 8,
  parameter int CNT_W   = 9
);
  logic               sym_clk_en;
  logic               restart;
  logic [1:0]         tx_data;
  logic [1:0]         rx_data;
  logic [DELAY_W-1:0] delay;
  logic               locked;
  logic [CNT_W-1:0]   window_err;
  logic [CNT_W-1:0]   best_err;
  logic [1:0]         tx_data_aligned;

  // Symbol source / status consumer side.
  modport master (
    output sym_clk_en, restart, tx_data, rx_data,
    input  delay, locked, window_err, best_err, tx_data_aligned
  );

  // Delay search block side.
  modport slave (
    input  sym_clk_en, restart, tx_data, rx_data,
    output delay, locked, window_err, best_err, tx_data_aligned
  );
endinterface

// File: rtl/sym_delay_search_tap_line.sv
// Tapped delay line of 2-bit symbols; tap 0 is the live input, tap k is
// the input k enabled ticks ago.
module sym_tap_line #(
  parameter int DEPTH = 127,
  parameter int SEL_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic [1:0]       in,
  input  logic [SEL_W-1:0] sel,
  output logic [1:0]       out
);

  logic [1:0] line_r [DEPTH];
  logic [1:0] taps_s [DEPTH+1];

  // Shift one symbol per enabled tick; reset empties the line to zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) line_r[i] <= 2'b00;
    end else if (clk_en) begin
      line_r[0] <= in;
      for (int i = 1; i < DEPTH; i++) line_r[i] <= line_r[i-1];
    end
  end

  // Flatten live input plus stored symbols into one tap vector.
  always_comb begin
    taps_s[0] = in;
    for (int k = 1; k <= DEPTH; k++) taps_s[k] = line_r[k-1];
  end

  // Tap select; an out-of-range select reads as symbol 0.
  always_comb begin
    out = 2'b00;
    for (int k = 0; k <= DEPTH; k++) out = (sel == SEL_W'(k)) ? taps_s[k] : out;
  end

endmodule

// File: rtl/sym_delay_search.sv
// Automatic RX/TX symbol alignment: sweeps candidate delays of the TX
// reference, counts mismatches against the sliced RX symbols per window and
// locks on the best delay. Drops lock when a window gets too noisy.
module sym_delay_search
  import sym_delay_search_pkg::*;
#(
  parameter int MAX_DELAY   = SDS_DEF_MAX_DELAY,
  parameter int DELAY_W     = 8,
  parameter int WIN_LEN     = SDS_DEF_WIN_LEN,
  parameter int CNT_W       = 9,
  parameter int LOCK_THRESH = 4,
  parameter int LOSS_THRESH = 32
) (
  input  logic               clk,
  input  logic               reset,
  sym_delay_search_if.slave  bus
);

  localparam int               WIN_W    = $clog2(WIN_LEN);
  localparam logic [CNT_W-1:0] ERR_ONES = {CNT_W{1'b1}};

  sds_state_e         state_r, state_s;
  logic [DELAY_W-1:0] delay_r, delay_s;
  logic [DELAY_W-1:0] best_delay_r, best_delay_s;
  logic [CNT_W-1:0]   best_err_r, best_err_s;
  logic [CNT_W-1:0]   window_err_r, window_err_s;
  logic [CNT_W-1:0]   err_acc_r, err_acc_s;
  logic [WIN_W-1:0]   win_cnt_r, win_cnt_s;
  logic               locked_r, locked_s;

  logic [1:0]         tap_s;
  logic               err_s;
  logic               win_end_s;
  logic [CNT_W-1:0]   total_s;
  logic [CNT_W-1:0]   min_err_s;

  sym_tap_line #(
    .DEPTH (MAX_DELAY),
    .SEL_W (DELAY_W)
  ) u_tap_line (
    .clk    (clk),
    .reset  (reset),
    .clk_en (bus.sym_clk_en),
    .in     (bus.tx_data),
    .sel    (delay_r),
    .out    (tap_s)
  );

  assign err_s     = sym_mismatch(tap_s, bus.rx_data);
  assign win_end_s = (win_cnt_r == WIN_W'(WIN_LEN - 1));
  assign total_s   = err_acc_r + CNT_W'(err_s);
  assign min_err_s = (total_s < best_err_r) ? total_s : best_err_r;
  assign locked_s  = (state_s == SDS_LOCKED);

  // Next-state: restart beats a tick; window end drives the search decisions.
  always_comb begin
    state_s      = state_r;
    delay_s      = delay_r;
    best_delay_s = best_delay_r;
    best_err_s   = best_err_r;
    window_err_s = window_err_r;
    win_cnt_s    = win_cnt_r;
    err_acc_s    = err_acc_r;
    if (bus.restart) begin
      state_s    = SDS_SEARCH;
      delay_s    = DELAY_W'(0);
      best_err_s = ERR_ONES;
      win_cnt_s  = WIN_W'(0);
      err_acc_s  = CNT_W'(0);
    end else if (bus.sym_clk_en) begin
      if (win_end_s) begin
        win_cnt_s    = WIN_W'(0);
        err_acc_s    = CNT_W'(0);
        window_err_s = total_s;
        case (state_r)
          SDS_SEARCH: begin
            if (total_s < best_err_r) begin
              best_err_s   = total_s;
              best_delay_s = delay_r;
            end else begin
              best_err_s   = best_err_r;
            end
            if (total_s == CNT_W'(0)) begin
              // Clean window: no point sweeping further.
              state_s    = SDS_LOCKED;
              best_err_s = CNT_W'(0);
            end else if (delay_r < DELAY_W'(MAX_DELAY)) begin
              delay_s = delay_r + DELAY_W'(1);
            end else if (min_err_s <= CNT_W'(LOCK_THRESH)) begin
              // Sweep done; the last window may itself be the best one.
              state_s = SDS_LOCKED;
              delay_s = (total_s < best_err_r) ? delay_r : best_delay_r;
            end else begin
              delay_s    = DELAY_W'(0);
              best_err_s = ERR_ONES;
            end
          end
          SDS_LOCKED: begin
            if (total_s > CNT_W'(LOSS_THRESH)) begin
              state_s    = SDS_SEARCH;
              delay_s    = DELAY_W'(0);
              best_err_s = ERR_ONES;
            end else begin
              delay_s = delay_r;
            end
          end
          default: begin
            state_s    = SDS_SEARCH;
            delay_s    = DELAY_W'(0);
            best_err_s = ERR_ONES;
          end
        endcase
      end else begin
        win_cnt_s = win_cnt_r + WIN_W'(1);
        err_acc_s = total_s;
      end
    end else begin
      state_s = state_r;
    end
  end

  // State and counter registers; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= SDS_SEARCH;
      delay_r      <= DELAY_W'(0);
      best_delay_r <= DELAY_W'(0);
      best_err_r   <= ERR_ONES;
      window_err_r <= CNT_W'(0);
      err_acc_r    <= CNT_W'(0);
      win_cnt_r    <= WIN_W'(0);
      locked_r     <= 1'b0;
    end else begin
      state_r      <= state_s;
      delay_r      <= delay_s;
      best_delay_r <= best_delay_s;
      best_err_r   <= best_err_s;
      window_err_r <= window_err_s;
      err_acc_r    <= err_acc_s;
      win_cnt_r    <= win_cnt_s;
      locked_r     <= locked_s;
    end
  end

  assign bus.delay           = delay_r;
  assign bus.locked          = locked_r;
  assign bus.window_err      = window_err_r;
  assign bus.best_err        = best_err_r;
  assign bus.tx_data_aligned = tap_s;

endmodule

// File: tb/tb_sym_delay_search.sv
// Self-checking bench for sym_delay_search with a shortened sweep
// (16 delays x 32-symbol windows). Window-end expectations are queued when
// the window stimulus is generated and popped after the window's last tick.
module tb_sym_delay_search;

  localparam int MAX_DELAY   = 15;
  localparam int DELAY_W     = 8;
  localparam int WIN_LEN     = 32;
  localparam int CNT_W       = 6;
  localparam int LOCK_THRESH = 4;
  localparam int LOSS_THRESH = 8;
  localparam int ONES        = (1 << CNT_W) - 1;

  typedef struct {
    logic locked;
    int   delay;
    int   werr;
    int   berr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sym_delay_search_if #(.DELAY_W(DELAY_W), .CNT_W(CNT_W)) bus ();

  sym_delay_search #(
    .MAX_DELAY   (MAX_DELAY),
    .DELAY_W     (DELAY_W),
    .WIN_LEN     (WIN_LEN),
    .CNT_W       (CNT_W),
    .LOCK_THRESH (LOCK_THRESH),
    .LOSS_THRESH (LOSS_THRESH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] hist   [32];        // hist[j] = tx symbol j+1 ticks ago
  logic [1:0] win_tx [WIN_LEN];
  logic [1:0] win_rx [WIN_LEN];
  logic [1:0] win_tap[WIN_LEN];

  function automatic logic [1:0] past(input int i, input int k);
    if (i >= k) return win_tx[i-k];
    return hist[k-i-1];
  endfunction

  task automatic clear_hist();
    for (int j = 0; j < 32; j++) hist[j] = 2'b00;
  endtask

  // Build one window: random TX, RX = TX delayed by ch (ch<0: random RX),
  // first inj symbols corrupted; werr counts mismatches seen at delay cand.
  task automatic gen_window(input int cand, input int ch, input int inj, output int werr);
    werr = 0;
    for (int i = 0; i < WIN_LEN; i++) begin
      win_tx[i] = 2'($urandom);
      win_rx[i] = (ch < 0) ? 2'($urandom) : past(i, ch);
      if (i < inj) win_rx[i] = win_rx[i] ^ 2'b01;
      win_tap[i] = past(i, cand);
      if (win_tap[i] != win_rx[i]) werr++;
    end
  endtask

  task automatic idle(input int n);
    bus.sym_clk_en = 1'b0;
    for (int c = 0; c < n; c++) begin
      bus.tx_data = 2'($urandom);
      bus.rx_data = 2'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // Drive the first n ticks of the generated window; aln counts ticks where
  // the DUT tap output differs from the symbol the bench expects there.
  task automatic drive_window(input int gap, input int n, output int aln);
    aln = 0;
    for (int i = 0; i < n; i++) begin
      if (gap > 0) idle($urandom_range(gap, 0));
      bus.tx_data    = win_tx[i];
      bus.rx_data    = win_rx[i];
      bus.sym_clk_en = 1'b1;
      #1;
      if (bus.tx_data_aligned !== win_tap[i]) aln++;
      @(posedge clk); #1;
      bus.sym_clk_en = 1'b0;
      for (int j = 31; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = win_tx[i];
    end
  endtask

  task automatic do_restart();
    bus.sym_clk_en = 1'b0;
    bus.restart    = 1'b1;
    @(posedge clk); #1;
    bus.restart    = 1'b0;
  endtask

  task automatic do_reset(input logic en);
    reset          = 1'b1;
    bus.sym_clk_en = en;
    bus.tx_data    = 2'($urandom);
    @(posedge clk); #1;
    reset          = 1'b0;
    bus.sym_clk_en = 1'b0;
    clear_hist();
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; bus.sym_clk_en = 1'b0; bus.restart = 1'b0;
    bus.tx_data = 2'b00; bus.rx_data = 2'b00;
    exp_q.push_back('{1'b0, 0, 0, ONES});
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_hist();
    e = exp_q.pop_front();
    n_cmp++; if (bus.locked !== e.locked) begin n_bad++; $display("FAIL reset locked got=%0b exp=%0b", bus.locked, e.locked); end
    n_cmp++; if (bus.delay !== DELAY_W'(e.delay)) begin n_bad++; $display("FAIL reset delay got=%0d exp=%0d", bus.delay, e.delay); end
    n_cmp++; if (bus.window_err !== CNT_W'(e.werr)) begin n_bad++; $display("FAIL reset window_err got=%0d exp=%0d", bus.window_err, e.werr); end
    n_cmp++; if (bus.best_err !== CNT_W'(e.berr)) begin n_bad++; $display("FAIL reset best_err got=%0d exp=%0d", bus.best_err, e.berr); end
    bus.tx_data = 2'b10; #1;
    n_cmp++; if (bus.tx_data_aligned !== 2'b10) begin n_bad++; $display("FAIL reset tap0 got=%0d exp=2", bus.tx_data_aligned); end
  endtask

  // From a fresh search: channel delay d, no errors. Early lock at the end of
  // window d, then two more clean locked windows.
  task automatic test_early_lock(input int d, input int gap, input string tag);
    exp_t e;
    int werr, aln, best, cand;
    best = ONES;
    for (int w = 0; w <= d + 2; w++) begin
      cand = (w <= d) ? w : d;
      gen_window(cand, d, 0, werr);
      if (werr < best) best = werr;
      if (w < d) exp_q.push_back('{1'b0, w + 1, werr, best});
      else       exp_q.push_back('{1'b1, d, 0, 0});
      drive_window(gap, WIN_LEN, aln);
      e = exp_q.pop_front();
      n_cmp++; if (aln !== 0) begin n_bad++; $display("FAIL %s w%0d tap_align bad_ticks=%0d exp=0", tag, w, aln); end
      n_cmp++; if (bus.locked !== e.locked) begin n_bad++; $display("FAIL %s w%0d locked got=%0b exp=%0b", tag, w, bus.locked, e.locked); end
      n_cmp++; if (bus.delay !== DELAY_W'(e.delay)) begin n_bad++; $display("FAIL %s w%0d delay got=%0d exp=%0d", tag, w, bus.delay, e.delay); end
      n_cmp++; if (bus.window_err !== CNT_W'(e.werr)) begin n_bad++; $display("FAIL %s w%0d window_err got=%0d exp=%0d", tag, w, bus.window_err, e.werr); end
      n_cmp++; if (bus.best_err !== CNT_W'(e.berr)) begin n_bad++; $display("FAIL %s w%0d best_err got=%0d exp=%0d", tag, w, bus.best_err, e.berr); end
    end
  endtask

  // Locked at d_old; the channel moves to d_new. One noisy window drops lock,
  // then the search relocks early at d_new.
  task automatic test_channel_switch(input int d_old, input int d_new);
    exp_t e;
    int werr, aln;
    gen_window(d_old, d_new, 0, werr);
    exp_q.push_back('{1'b0, 0, werr, ONES});
    drive_window(0, WIN_LEN, aln);
    e = exp_q.pop_front();
    n_cmp++; if (bus.locked !== e.locked) begin n_bad++; $display("FAIL loss locked got=%0b exp=%0b", bus.locked, e.locked); end
    n_cmp++; if (bus.delay !== DELAY_W'(e.delay)) begin n_bad++; $display("FAIL loss delay got=%0d exp=%0d", bus.delay, e.delay); end
    n_cmp++; if (bus.window_err !== CNT_W'(e.werr)) begin n_bad++; $display("FAIL loss window_err got=%0d exp=%0d", bus.window_err, e.werr); end
    n_cmp++; if (bus.best_err !== CNT_W'(e.berr)) begin n_bad++; $display("FAIL loss best_err got=%0d exp=%0d", bus.best_err, e.berr); end
    test_early_lock(d_new, 0, "relock");
  endtask

  // Independent random RX: two full sweeps plus two windows, never locking.
  task automatic test_random_nolock();
    exp_t e;
    int werr, aln, best, cand;
    do_restart();
    best = ONES;
    for (int w = 0; w < 2 * (MAX_DELAY + 1) + 2; w++) begin
      cand = w % (MAX_DELAY + 1);
      gen_window(cand, -1, 0, werr);
      if (werr < best) best = werr;
      if (cand == MAX_DELAY) begin
        exp_q.push_back('{1'b0, 0, werr, ONES});
        best = ONES;
      end else begin
        exp_q.push_back('{1'b0, cand + 1, werr, best});
      end
      drive_window(0, WIN_LEN, aln);
      e = exp_q.pop_front();
      n_cmp++; if (bus.locked !== e.locked) begin n_bad++; $display("FAIL random w%0d locked got=%0b exp=%0b", w, bus.locked, e.locked); end
      n_cmp++; if (bus.delay !== DELAY_W'(e.delay)) begin n_bad++; $display("FAIL random w%0d delay got=%0d exp=%0d", w, bus.delay, e.delay); end
      n_cmp++; if (bus.window_err !== CNT_W'(e.werr)) begin n_bad++; $display("FAIL random w%0d window_err got=%0d exp=%0d", w, bus.window_err, e.werr); end
      n_cmp++; if (bus.best_err !== CNT_W'(e.berr)) begin n_bad++; $display("FAIL random w%0d best_err got=%0d exp=%0d", w, bus.best_err, e.berr); end
    end
  endtask

  // Channel delay 10 with 2 corrupted symbols per window: no early lock, lock
  // at the end of the sweep on delay 10 with best_err 2, then stays locked.
  task automatic test_sweep_lock();
    exp_t e;
    int werr, aln, best, cand;
    do_restart();
    best = ONES;
    for (int w = 0; w <= MAX_DELAY + 1; w++) begin
      cand = (w <= MAX_DELAY) ? w : 10;
      gen_window(cand, 10, 2, werr);
      if (werr < best) best = werr;
      if (w < MAX_DELAY)       exp_q.push_back('{1'b0, w + 1, werr, best});
      else if (w == MAX_DELAY) exp_q.push_back('{1'b1, 10, werr, 2});
      else                     exp_q.push_back('{1'b1, 10, 2, 2});
      drive_window(0, WIN_LEN, aln);
      e = exp_q.pop_front();
      n_cmp++; if (aln !== 0) begin n_bad++; $display("FAIL sweep w%0d tap_align bad_ticks=%0d exp=0", w, aln); end
      n_cmp++; if (bus.locked !== e.locked) begin n_bad++; $display("FAIL sweep w%0d locked got=%0b exp=%0b", w, bus.locked, e.locked); end
      n_cmp++; if (bus.delay !== DELAY_W'(e.delay)) begin n_bad++; $display("FAIL sweep w%0d delay got=%0d exp=%0d", w, bus.delay, e.delay); end
      n_cmp++; if (bus.window_err !== CNT_W'(e.werr)) begin n_bad++; $display("FAIL sweep w%0d window_err got=%0d exp=%0d", w, bus.window_err, e.werr); end
      n_cmp++; if (bus.best_err !== CNT_W'(e.berr)) begin n_bad++; $display("FAIL sweep w%0d best_err got=%0d exp=%0d", w, bus.best_err, e.berr); end
    end
  endtask

  // Restart mid-lock and mid-search (sym_clk_en low): lock and delay drop,
  // window_err is held; then a fresh aligned search still works.
  task automatic test_restart();
    exp_t e;
    int werr, aln;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) gen_window(10, 10, 0, werr);
      else        gen_window(0, -1, 0, werr);
      drive_window(0, (k == 0) ? 7 : 20, aln);
      exp_q.push_back('{1'b0, 0, 2, ONES});
      do_restart();
      e = exp_q.pop_front();
      n_cmp++; if (bus.locked !== e.locked) begin n_bad++; $display("FAIL restart%0d locked got=%0b exp=%0b", k, bus.locked, e.locked); end
      n_cmp++; if (bus.delay !== DELAY_W'(e.delay)) begin n_bad++; $display("FAIL restart%0d delay got=%0d exp=%0d", k, bus.delay, e.delay); end
      n_cmp++; if (bus.window_err !== CNT_W'(e.werr)) begin n_bad++; $display("FAIL restart%0d window_err got=%0d exp=%0d", k, bus.window_err, e.werr); end
      n_cmp++; if (bus.best_err !== CNT_W'(e.berr)) begin n_bad++; $display("FAIL restart%0d best_err got=%0d exp=%0d", k, bus.best_err, e.berr); end
    end
    test_early_lock(4, 0, "after_restart");
  endtask

  // Reset mid-lock (with a tick pending) and mid-search (sym_clk_en low):
  // everything clears including window_err and the delay line.
  task automatic test_reset_mid();
    exp_t e;
    int werr, aln;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) gen_window(4, 4, 0, werr);
      else        gen_window(0, -1, 0, werr);
      drive_window(0, (k == 0) ? 9 : 12, aln);
      exp_q.push_back('{1'b0, 0, 0, ONES});
      do_reset((k == 0) ? 1'b1 : 1'b0);
      e = exp_q.pop_front();
      n_cmp++; if (bus.locked !== e.locked) begin n_bad++; $display("FAIL reset_mid%0d locked got=%0b exp=%0b", k, bus.locked, e.locked); end
      n_cmp++; if (bus.delay !== DELAY_W'(e.delay)) begin n_bad++; $display("FAIL reset_mid%0d delay got=%0d exp=%0d", k, bus.delay, e.delay); end
      n_cmp++; if (bus.window_err !== CNT_W'(e.werr)) begin n_bad++; $display("FAIL reset_mid%0d window_err got=%0d exp=%0d", k, bus.window_err, e.werr); end
      n_cmp++; if (bus.best_err !== CNT_W'(e.berr)) begin n_bad++; $display("FAIL reset_mid%0d best_err got=%0d exp=%0d", k, bus.best_err, e.berr); end
    end
    test_early_lock(6, 0, "after_reset");
  endtask

  // Same early-lock scenario with sym_clk_en at about 1/4 duty.
  task automatic test_gated();
    do_restart();
    test_early_lock(9, 6, "gated");
  endtask

  initial begin
    test_reset();
    test_early_lock(7, 0, "early");
    test_channel_switch(7, 3);
    test_random_nolock();
    test_sweep_lock();
    test_restart();
    test_reset_mid();
    test_gated();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sym_delay_search.md
Name: sym_delay_search

Overview:
- Automatic RX/TX symbol-alignment stage. It sits directly downstream of slicer_4_ask and replaces the hand-tuned constant delay fed to config_data_delay.
- Keeps an internal tapped delay line of the 2-bit TX reference symbols. It sweeps candidate delays, counts symbol mismatches against sliced rx_data over a fixed window, and locks on the best delay.
- Exports the locked delay and per-window error counts for the error-measurement blocks and LEDs.

Parameters:
- MAX_DELAY, 127, largest candidate delay in symbols (tap count = MAX_DELAY+1)
- DELAY_W, 8, width of delay outputs
- WIN_LEN, 256, symbols per measurement window (power of two)
- CNT_W, 9, width of error counters (holds 0..WIN_LEN)
- LOCK_THRESH, 4, max best-window errors accepted at end of sweep
- LOSS_THRESH, 32, window errors above which lock is dropped

Ports:
- clk  in  1  system clock (sys_clk)
- reset  in  1  synchronous, active-high reset
- sym_clk_en  in  1  symbol-rate enable; all state advances only when high
- restart  in  1  synchronous request to abandon lock/search and re-sweep from delay 0
- tx_data  in  2  TX reference symbol (lfsr sym_out[1:0])
- rx_data  in  2  sliced RX symbol
- delay  out  DELAY_W  current candidate delay, or locked delay
- locked  out  1  high while in LOCKED
- window_err  out  CNT_W  error total of the last completed window
- best_err  out  CNT_W  minimum window total in the current sweep
- tx_data_aligned  out  2  tx_data delayed by delay symbols (tap output)

Behaviour:
- Reset (sync, checked each clk edge regardless of sym_clk_en):
  - delay=0, locked=0, window_err=0, best_err=all-ones.
  - State=SEARCH; internal best_delay=0, win_cnt=0, err_acc=0, delay line cleared to 0.
- Delay line:
  - On each tick (sym_clk_en=1), shift in tx_data.
  - tap[0]=tx_data (combinational); tap[k]=tx_data k ticks ago.
  - tx_data_aligned=tap[delay], combinational.
- Per tick:
  - e = (tap[delay] != rx_data).
  - win_cnt increments, wrapping at WIN_LEN-1 → 0.
  - err_acc += e; err_acc is cleared at window end.
- Window end (tick with win_cnt==WIN_LEN-1): total = err_acc + e, and window_err <= total.
- SEARCH at window end:
  - If total < best_err: best_err <= total and best_delay <= delay.
  - If total == 0: go to LOCKED with delay unchanged and best_err=0 (early lock).
  - Else if delay < MAX_DELAY: delay <= delay+1.
  - Else (sweep done):
    - If min(best_err, total) ≤ LOCK_THRESH: go to LOCKED with delay <= best delay.
    - Otherwise: delay <= 0, best_err <= all-ones, stay in SEARCH.
  - A delay change takes effect from the next tick. There is no settle window, because the tap line is always full.
- LOCKED:
  - delay is held.
  - At window end, if total > LOSS_THRESH: locked drops on that same edge, state=SEARCH, delay <= 0, best_err <= all-ones.
- locked is registered and equals (state==LOCKED).
- restart=1 on any clk edge (no sym_clk_en needed):
  - Same effect as loss of lock, plus win_cnt=0 and err_acc=0.
  - Delay line contents are kept.
  - Priority: reset > restart > tick.
- sym_clk_en low: every register holds.
- Counters are sized so err_acc never overflows; total ≤ WIN_LEN.
- Search time for a full sweep = (MAX_DELAY+1)·WIN_LEN ticks.

Decomposition:
- Shared defines file gets:
  - FSM state encodings SDS_SEARCH and SDS_LOCKED
  - default WIN_LEN / MAX_DELAY as macros next to LFSR_LEN
- One sub-module, sym_tap_line:
  - parameterised shift register of 2-bit symbols with sym_clk_en and a combinational tap mux
  - ports clk, reset, clk_en, in, sel, out
- The FSM and counters live in sym_delay_search.

Test Plan:
- rx_data = tx_data delayed exactly 52 ticks, no errors.
  - Early lock at the end of window 53 (53·256 ticks).
  - delay=52, window_err=0, tx_data_aligned==rx_data from then on.
- rx_data independent random: never locks.
  - window_err ≈ 192 each window.
  - delay wraps 127→0 and best_err resets to all-ones each sweep.
- Delay 10 with 2 injected errors per window: no early lock.
  - Lock at end of sweep (128 windows), delay=10, best_err=2.
- Locked at 52, then channel delay switched to 20.
  - Next completed window has window_err > 32; locked falls on that edge and delay=0.
  - Relocks early at delay=20 after 21 more windows.
- restart, and separately reset, asserted mid-search and mid-lock (also with sym_clk_en low).
  - Next edge: locked=0, delay=0, best_err=all-ones.
  - After reset only: window_err=0 and the delay line is cleared.
- sym_clk_en gated at 1/4 duty with random gaps: results identical to the contiguous-tick run at the same tick counts.
